// File: rtl/unload_8bit_pkg.sv
// unload_8bit_pkg: widths and FSM states shared by the frame unloader and the input shifter
package unload_8bit_pkg;
    localparam int DATA_W      = 8;
    localparam int FRAME_DEPTH = 8;
    localparam int CNT_W       = 3;
    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/unload_8bit.sv
// unload_8bit: captures an 8-word frame and streams it out oldest-first (in_7 .. in_0) over valid/ready
module unload_8bit
    import unload_8bit_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FRAME_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic [WIDTH-1:0] in_3,
    input  logic [WIDTH-1:0] in_4,
    input  logic [WIDTH-1:0] in_5,
    input  logic [WIDTH-1:0] in_6,
    input  logic [WIDTH-1:0] in_7,
    input  logic             load,
    output logic             load_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             last,
    output logic             busy
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q [DEPTH];
    logic [WIDTH-1:0] word_d [DEPTH];
    logic [WIDTH-1:0] in_w   [DEPTH];
    logic [CNT_W-1:0] idx;

    assign in_w  = '{in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7};
    assign busy  = (state_q == SHIFT);
    assign valid = busy;
    assign idx   = LAST - cnt_q;
    assign data  = valid ? word_q[idx] : '0;
    assign last  = valid && (cnt_q == LAST);

    // next state: capture in IDLE or on the final transfer, otherwise advance per accepted word
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        load_ready = 1'b0;
        if (state_q == IDLE) begin
            load_ready = 1'b1;
            if (load) begin
                word_d  = in_w;
                cnt_d   = '0;
                state_d = SHIFT;
            end
        end else if (ready) begin
            if (cnt_q != LAST) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                load_ready = 1'b1;
                cnt_d      = '0;
                if (load) word_d = in_w;
                else      state_d = IDLE;
            end
        end
    end

    // state, counter and frame storage; reset clears everything so outputs drop immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end
endmodule

// File: doc/unload_8bit.md
UNLOAD_8BIT -- requirements
Module: unload_8bit

Interface
REQ-001 Parameter: WIDTH, 8, sample width in bits (all data ports).
REQ-002 Parameter: DEPTH, 8, number of parallel words per frame; fixed at 8 in this block.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: in_0 .. in_7  input  WIDTH each  parallel frame words; in_7 is the oldest sample in the FFT sample order.
REQ-006 Port: load  input  1  request to capture in_0..in_7.
REQ-007 Port: load_ready  output  1  high when a load is accepted this cycle.
REQ-008 Port: data  output  WIDTH  serial output word.
REQ-009 Port: valid  output  1  data holds a valid word.
REQ-010 Port: ready  input  1  downstream accepts data when valid&ready.
REQ-011 Port: last  output  1  high with the final word (in_0) of a frame.
REQ-012 Port: busy  output  1  high while a frame is held or streaming.

Function
REQ-013 The block is the inverse of the 8-deep serial-to-parallel input shifter: it emits one captured frame word per accepted transfer, in order in_7, in_6, ... in_0, so feeding its output into that shifter with en=valid&ready rebuilds the same frame.
REQ-014 FSM has two states: IDLE (no frame held) and SHIFT (frame held, streaming).
REQ-015 IDLE: load_ready=1; on load=1, capture all 8 words, clear word counter to 0, go to SHIFT; valid rises on the next cycle.
REQ-016 SHIFT: valid=1, data=captured word indexed by 7-count, last=1 when count=7.
REQ-017 On valid&ready with count<7, increment count; data changes on the next cycle.
REQ-018 On valid&ready with count=7 and load=0, go to IDLE; valid=0 on the next cycle.
REQ-019 On valid&ready with count=7 and load=1 (simultaneous event), load_ready=1, capture the new frame, clear count, stay in SHIFT: back-to-back frames with no gap cycle.
REQ-020 In SHIFT, load_ready=0 except per REQ-019; load otherwise ignored; captured words never change mid-frame.
REQ-021 valid=1 with ready=0 holds data, last, and count stable for any number of cycles (no word dropped or repeated).
REQ-022 busy equals (state==SHIFT); load_ready is combinational from state, count, ready, and valid, never from load.
REQ-023 Counter is 3 bits and never wraps beyond 7 within a frame.

Reset
REQ-024 rst=1 asynchronously forces state=IDLE, count=0, captured words=0; while in reset: data=0, valid=0, last=0, busy=0.
REQ-025 Reset asserted mid-frame discards the remaining words; after release the block is in IDLE and accepts a new load on the first clock edge.

Structure
REQ-026 A shared package holds WIDTH, DEPTH, the counter width (3), and the two-value state enumeration, shared with the input shifter.
REQ-027 No sub-module is required; storage, counter, and FSM live in unload_8bit.

Verification
REQ-028 Frame in_0..in_7 = 0x10..0x17, ready=1 constantly -> data 0x17,0x16,...,0x10 on 8 consecutive cycles, last only with 0x10, then valid=0.
REQ-029 Same frame, ready toggling 1,0,1,0 -> each word presented until accepted, exactly 8 transfers, order unchanged.
REQ-030 Frame A=0xA0..0xA7, load held high with frame B=0xB0..0xB7 presented at A's last transfer -> 0xA0 is followed directly by 0xB7 with no idle cycle.
REQ-031 load pulsed during SHIFT at count=3 -> ignored, load_ready=0, frame output unchanged.
REQ-032 rst asserted after 4 words -> valid=0 and data=0 immediately (asynchronously); after release a new load 0x20..0x27 streams 0x27 first.
REQ-033 Loopback into the 8-deep input shifter with en=valid&ready -> shifter outputs out_0..out_7 equal the original in_0..in_7.
